// File: rtl/rst_sequencer.sv
// Power-up / camera reset sequencer: waits for a stable PLL lock, then steps the OV7670 PWDN and RESET pins
// and finally releases sys_rst. Define RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss event counter.
module rst_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned CAM_RST_CYCLES     = 50000,
  parameter int unsigned CAM_WAKE_CYCLES    = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sw_restart,
  output logic       sys_rst,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned MAX_A  = (LOCK_STABLE_CYCLES > CAM_RST_CYCLES) ? LOCK_STABLE_CYCLES : CAM_RST_CYCLES;
  localparam int unsigned MAX_N  = (MAX_A > CAM_WAKE_CYCLES) ? MAX_A : CAM_WAKE_CYCLES;
  localparam int unsigned CW     = ($clog2(MAX_N + 1) > 20) ? $clog2(MAX_N + 1) : 20;
  localparam logic [CW-1:0] LIM_STABLE = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LIM_RST    = CW'(CAM_RST_CYCLES - 1);
  localparam logic [CW-1:0] LIM_WAKE   = CW'(CAM_WAKE_CYCLES - 1);

  typedef enum logic [2:0] {WAIT_LOCK, STABLE, CAM_RST, CAM_WAKE, RUN} state_t;

  logic          r_sync1, r_lock_s;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          w_sys_rst, w_cam_pwdn, w_cam_rst_n, w_ready;
  logic          r_sys_rst, r_cam_pwdn, r_cam_rst_n, r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // Counter restarts on every state change and only runs in the timed states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == STABLE || r_state == CAM_RST || r_state == CAM_WAKE)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    if (r_state != WAIT_LOCK && !r_lock_s) begin
      w_next = WAIT_LOCK;
    end else begin
      case (r_state)
        WAIT_LOCK: if (r_lock_s)            w_next = STABLE;
        STABLE:    if (r_cnt == LIM_STABLE) w_next = CAM_RST;
        CAM_RST:   if (r_cnt == LIM_RST)    w_next = CAM_WAKE;
        CAM_WAKE:  if (r_cnt == LIM_WAKE)   w_next = RUN;
        RUN:       if (sw_restart)          w_next = CAM_RST;
        default:                            w_next = WAIT_LOCK;
      endcase
    end
  end

  // Decoded from the next state so the registered pins move on the same edge as the state.
  always_comb begin
    w_sys_rst   = 1'b1;
    w_cam_pwdn  = 1'b1;
    w_cam_rst_n = 1'b0;
    w_ready     = 1'b0;
    case (w_next)
      CAM_RST: begin
        w_cam_pwdn = 1'b0;
      end
      CAM_WAKE: begin
        w_cam_pwdn  = 1'b0;
        w_cam_rst_n = 1'b1;
      end
      RUN: begin
        w_sys_rst   = 1'b0;
        w_cam_pwdn  = 1'b0;
        w_cam_rst_n = 1'b1;
        w_ready     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sys_rst   <= 1'b1;
      r_cam_pwdn  <= 1'b1;
      r_cam_rst_n <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_sys_rst   <= w_sys_rst;
      r_cam_pwdn  <= w_cam_pwdn;
      r_cam_rst_n <= w_cam_rst_n;
      r_ready     <= w_ready;
    end
  end

  assign sys_rst   = r_sys_rst;
  assign cam_pwdn  = r_cam_pwdn;
  assign cam_rst_n = r_cam_rst_n;
  assign ready     = r_ready;

`ifdef RST_SEQ_LOSS_CNT_EN
  logic       w_lock_loss;
  logic [7:0] r_loss_cnt;

  assign w_lock_loss = (r_state != WAIT_LOCK) && !r_lock_s;

  always_ff @(posedge clk) begin
    if (rst)
      r_loss_cnt <= '0;
    else if (w_lock_loss && r_loss_cnt != 8'hFF)
      r_loss_cnt <= r_loss_cnt + 8'd1;
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: a progress-based reference model queues the expected pin/count vector
// for every edge, and an independent monitor pops and compares it one time unit after each rising edge.
module tb_rst_sequencer;

  localparam int L = 8;
  localparam int R = 16;
  localparam int W = 16;
  localparam int T = L + R + W;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_restart = 1'b0;
  logic       sys_rst, cam_pwdn, cam_rst_n, ready;
  logic [7:0] lock_loss_cnt;

  always #5 clk = ~clk;

  rst_sequencer #(
    .LOCK_STABLE_CYCLES(L),
    .CAM_RST_CYCLES    (R),
    .CAM_WAKE_CYCLES   (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sw_restart   (sw_restart),
    .sys_rst      (sys_rst),
    .cam_pwdn     (cam_pwdn),
    .cam_rst_n    (cam_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // Model: m_p = -1 while waiting for lock, otherwise cycles of progress since the stable window began.
  int          m_p   = -1;
  bit          m_s1  = 1'b0;
  bit          m_s2  = 1'b0;
  int          m_cnt = 0;
  logic [11:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [11:0] model_outs();
    logic [3:0] pins;
    if (m_p < L)      pins = 4'b1100;
    else if (m_p < L + R) pins = 4'b1000;
    else if (m_p < T) pins = 4'b1010;
    else              pins = 4'b0011;
    return {pins, 8'(m_cnt)};
  endfunction

  task automatic step(input bit r, input bit pl, input bit sw);
    @(negedge clk);
    rst = r;
    pll_locked = pl;
    sw_restart = sw;
    if (r) begin
      m_p = -1; m_s1 = 1'b0; m_s2 = 1'b0; m_cnt = 0;
    end else begin
      if (m_p >= 0 && !m_s2) begin
        m_p = -1;
        if (LOSS_EN && m_cnt < 255) m_cnt++;
      end else if (m_p < 0 && m_s2) m_p = 0;
      else if (m_p == T && sw)     m_p = L;
      else if (m_p >= 0 && m_p < T) m_p++;
      m_s2 = m_s1;
      m_s1 = pl;
    end
    exp_q.push_back(model_outs());
  endtask

  initial begin : monitor
    logic [11:0] got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {sys_rst, cam_pwdn, cam_rst_n, ready, lock_loss_cnt};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL outputs t=%0t {sys_rst,pwdn,rst_n,ready,cnt} got=%b_%h required=%b_%h",
                   $time, got[11:8], got[7:0], e[11:8], e[7:0]);
        end
      end
    end
  end

  initial begin : stim
    int n;
    repeat (3) step(1, 0, 0);
    // clean bring-up
    repeat (60) step(0, 1, 0);
    // lock glitch during the stable window
    repeat (3) step(0, 0, 0);
    repeat (5) step(0, 1, 0);
    step(0, 0, 0);
    repeat (60) step(0, 1, 0);
    // software restart in RUN, then in CAM_WAKE
    step(0, 1, 1);
    n = 0;
    while (m_p < L + R + 2 && n < 100) begin step(0, 1, 0); n++; end
    step(0, 1, 1);
    repeat (40) step(0, 1, 0);
    // lock loss in RUN then relock
    repeat (4) step(0, 0, 0);
    repeat (60) step(0, 1, 0);
    // rst on the same edge a lock loss would be forced in CAM_WAKE
    step(0, 1, 1);
    n = 0;
    while (m_p < L + R + 3 && n < 100) begin step(0, 1, 0); n++; end
    step(0, 0, 0);
    n = 0;
    while (m_s2 && n < 10) begin step(0, 0, 0); n++; end
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (50) step(0, 1, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) != 0), ($urandom_range(0, 9) == 0));
    // repeated lock loss after reaching RUN
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (m_p != T && n < 100) begin step(0, 1, $urandom_range(0, 1)); n++; end
      repeat (3) step(0, 0, 0);
    end
    repeat (50) step(0, 1, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
